gear_input_conditioner: RTL and testbench

GEAR_INPUT_CONDITIONER -- requirements
Module: gear_input_conditioner

---
 rtl/gear_pkg.sv | 16 +
 rtl/gear_input_conditioner_if.sv | 29 ++
 rtl/debounce_cell.sv | 52 +++++
 rtl/gear_input_conditioner.sv | 73 +++++++
 tb/tb_gear_input_conditioner.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/gear_pkg.sv
// Shared constants for the landing-gear input conditioner.
//   DefaultDebounceCycles : stable cycles before a debounced output changes
//   DefaultTimerCycles    : cycles from Timer deassertion to TimeUp
//   *RstVal               : safe parked value of each debounced channel
package gear_pkg;

    localparam int unsigned DefaultDebounceCycles = 4;
    localparam int unsigned DefaultTimerCycles    = 8;

    // Parked state: lever down, on ground, gear down and locked.
    localparam logic LeverRstVal  = 1'b1;
    localparam logic GroundRstVal = 1'b1;
    localparam logic DownRstVal   = 1'b1;
    localparam logic UpRstVal     = 1'b0;

endpackage

// File: rtl/gear_input_conditioner_if.sv
// Signal bundle between the landing gear sensors/controller and the conditioner.
//   master : drives raw switch inputs and Timer, receives conditioned outputs
//   slave  : the conditioner itself
interface gear_input_conditioner_if;

    logic LeverRaw;
    logic GroundRaw;
    logic DownRaw;
    logic UpRaw;
    logic Timer;

    logic Lever;
    logic PlaneOnGround;
    logic GearIsDown;
    logic GearIsUp;
    logic TimeUp;
    logic SensorFault;

    modport master (
        output LeverRaw, GroundRaw, DownRaw, UpRaw, Timer,
        input  Lever, PlaneOnGround, GearIsDown, GearIsUp, TimeUp, SensorFault
    );

    modport slave (
        input  LeverRaw, GroundRaw, DownRaw, UpRaw, Timer,
        output Lever, PlaneOnGround, GearIsDown, GearIsUp, TimeUp, SensorFault
    );

endinterface

// File: rtl/debounce_cell.sv
// One debounce channel: two-flop synchronizer, stability counter, output flop.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (parks everything at RST_VAL)
//   raw   : asynchronous switch input
//   deb   : debounced, registered output
module debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            deb_q   <= RST_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter toggles the output on the edge it would reach DEBOUNCE_CYCLES,
    // so it never holds more than DEBOUNCE_CYCLES-1 and cannot wrap.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/gear_input_conditioner.sv
// Landing gear input conditioner: debounces four switch inputs, runs the
// takeoff-delay timer and latches a sticky fault when both limit switches
// report active.
//   Clock : rising-edge clock
//   Clear : asynchronous active-low reset
//   bus   : raw inputs, Timer restart, conditioned outputs (slave modport)
module gear_input_conditioner
    import gear_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned TIMER_CYCLES    = DefaultTimerCycles
) (
    input logic                     Clock,
    input logic                     Clear,
    gear_input_conditioner_if.slave bus
);

    localparam int unsigned TimerW = $clog2(TIMER_CYCLES + 1);

    logic gear_down, gear_up;

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(LeverRstVal)) u_lever (
        .clk(Clock), .rst_n(Clear), .raw(bus.LeverRaw), .deb(bus.Lever)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(GroundRstVal)) u_ground (
        .clk(Clock), .rst_n(Clear), .raw(bus.GroundRaw), .deb(bus.PlaneOnGround)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(DownRstVal)) u_down (
        .clk(Clock), .rst_n(Clear), .raw(bus.DownRaw), .deb(gear_down)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(UpRstVal)) u_up (
        .clk(Clock), .rst_n(Clear), .raw(bus.UpRaw), .deb(gear_up)
    );

    assign bus.GearIsDown = gear_down;
    assign bus.GearIsUp   = gear_up;

    logic [TimerW-1:0] tcnt_q, tcnt_d;
    logic              time_up_q, time_up_d;
    logic              fault_q, fault_d;

    // Timer is already synchronous to Clock, so it is used directly.
    always_comb begin
        tcnt_d = tcnt_q;
        if (bus.Timer) begin
            tcnt_d = '0;
        end else if (tcnt_q != TimerW'(TIMER_CYCLES)) begin
            tcnt_d = tcnt_q + TimerW'(1);
        end
        // Registering the compare on the next count keeps TimeUp aligned with tcnt_q.
        time_up_d = (tcnt_d == TimerW'(TIMER_CYCLES));
        fault_d   = fault_q | (gear_down & gear_up);
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            tcnt_q    <= '0;
            time_up_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            time_up_q <= time_up_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.TimeUp      = time_up_q;
    assign bus.SensorFault = fault_q;

endmodule

// File: tb/tb_gear_input_conditioner.sv
// Directed self-checking bench for gear_input_conditioner (DEBOUNCE 4, TIMER 8).
module tb_gear_input_conditioner;

    logic Clock;
    logic Clear;
    int   checks;
    int   fails;

    gear_input_conditioner_if bus ();

    gear_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .TIMER_CYCLES   (8)
    ) dut (
        .Clock(Clock),
        .Clear(Clear),
        .bus  (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Clear         = 1'b0;
        bus.LeverRaw  = 1'b0;
        bus.GroundRaw = 1'b0;
        bus.DownRaw   = 1'b0;
        bus.UpRaw     = 1'b1;
        bus.Timer     = 1'b0;
        tick(3);
        checks++; if (bus.Lever !== 1'b1) begin fails++;
            $display("FAIL reset_lever got %b want 1", bus.Lever); end
        checks++; if (bus.PlaneOnGround !== 1'b1) begin fails++;
            $display("FAIL reset_ground got %b want 1", bus.PlaneOnGround); end
        checks++; if (bus.GearIsDown !== 1'b1) begin fails++;
            $display("FAIL reset_down got %b want 1", bus.GearIsDown); end
        checks++; if (bus.GearIsUp !== 1'b0) begin fails++;
            $display("FAIL reset_up got %b want 0", bus.GearIsUp); end
        checks++; if (bus.TimeUp !== 1'b0) begin fails++;
            $display("FAIL reset_timeup got %b want 0", bus.TimeUp); end
        checks++; if (bus.SensorFault !== 1'b0) begin fails++;
            $display("FAIL reset_fault got %b want 0", bus.SensorFault); end
        // Release with raw inputs at parked values: nothing may toggle.
        bus.LeverRaw  = 1'b1;
        bus.GroundRaw = 1'b1;
        bus.DownRaw   = 1'b1;
        bus.UpRaw     = 1'b0;
        bus.Timer     = 1'b1;
        tick(1);
        Clear = 1'b1;
        tick(8);
        checks++;
        if ({bus.Lever, bus.PlaneOnGround, bus.GearIsDown, bus.GearIsUp, bus.TimeUp,
             bus.SensorFault} !== 6'b111000) begin
            fails++;
            $display("FAIL release_parked got %b%b%b%b%b%b want 111000", bus.Lever,
                     bus.PlaneOnGround, bus.GearIsDown, bus.GearIsUp, bus.TimeUp,
                     bus.SensorFault);
        end
    endtask

    task automatic test_lever_debounce();
        bus.LeverRaw = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            checks++;
            if (bus.Lever !== ((e < 6) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL lever_fall edge %0d got %b want %b", e, bus.Lever,
                         (e < 6) ? 1'b1 : 1'b0);
            end
        end
        checks++;
        if ({bus.PlaneOnGround, bus.GearIsDown, bus.GearIsUp} !== 3'b110) begin
            fails++;
            $display("FAIL lever_others got %b%b%b want 110", bus.PlaneOnGround,
                     bus.GearIsDown, bus.GearIsUp);
        end
        bus.LeverRaw = 1'b1;
        tick(5);
        checks++; if (bus.Lever !== 1'b0) begin fails++;
            $display("FAIL lever_rise_early got %b want 0", bus.Lever); end
        tick(1);
        checks++; if (bus.Lever !== 1'b1) begin fails++;
            $display("FAIL lever_rise got %b want 1", bus.Lever); end
    endtask

    task automatic test_glitch();
        bus.GroundRaw = 1'b0;
        tick(3);
        bus.GroundRaw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            if (e > 1) tick(1);
            checks++;
            if (bus.PlaneOnGround !== 1'b1) begin
                fails++;
                $display("FAIL ground_glitch step %0d got %b want 1", e, bus.PlaneOnGround);
            end
        end
    endtask

    task automatic test_timer();
        bus.Timer = 1'b1;
        tick(1);
        bus.Timer = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            tick(1);
            checks++;
            if (bus.TimeUp !== ((e >= 8) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL timer edge %0d got %b want %b", e, bus.TimeUp,
                         (e >= 8) ? 1'b1 : 1'b0);
            end
        end
        bus.Timer = 1'b1;
        tick(1);
        checks++; if (bus.TimeUp !== 1'b0) begin fails++;
            $display("FAIL timer_restart got %b want 0", bus.TimeUp); end
    endtask

    task automatic test_fault();
        bus.UpRaw = 1'b1;
        tick(6);
        checks++; if (bus.GearIsUp !== 1'b1) begin fails++;
            $display("FAIL fault_up_rise got %b want 1", bus.GearIsUp); end
        checks++; if (bus.SensorFault !== 1'b0) begin fails++;
            $display("FAIL fault_early got %b want 0", bus.SensorFault); end
        tick(1);
        checks++; if (bus.SensorFault !== 1'b1) begin fails++;
            $display("FAIL fault_set got %b want 1", bus.SensorFault); end
        bus.UpRaw = 1'b0;
        tick(6);
        checks++; if (bus.GearIsUp !== 1'b0) begin fails++;
            $display("FAIL fault_up_fall got %b want 0", bus.GearIsUp); end
        checks++; if (bus.SensorFault !== 1'b1) begin fails++;
            $display("FAIL fault_sticky got %b want 1", bus.SensorFault); end
        // Debounce keeps working while the fault is latched.
        bus.DownRaw = 1'b0;
        tick(6);
        checks++; if (bus.GearIsDown !== 1'b0) begin fails++;
            $display("FAIL fault_down_follow got %b want 0", bus.GearIsDown); end
        bus.DownRaw = 1'b1;
        tick(6);
        checks++; if (bus.SensorFault !== 1'b1) begin fails++;
            $display("FAIL fault_still got %b want 1", bus.SensorFault); end
        Clear = 1'b0;
        #1;
        checks++; if (bus.SensorFault !== 1'b0) begin fails++;
            $display("FAIL fault_clear got %b want 0", bus.SensorFault); end
        tick(1);
        Clear = 1'b1;
        tick(3);
        checks++; if (bus.SensorFault !== 1'b0) begin fails++;
            $display("FAIL fault_after_release got %b want 0", bus.SensorFault); end
    endtask

    task automatic test_reset_mid_debounce();
        bus.DownRaw = 1'b0;
        tick(4);
        Clear = 1'b0;
        tick(1);
        checks++; if (bus.GearIsDown !== 1'b1) begin fails++;
            $display("FAIL middeb_in_reset got %b want 1", bus.GearIsDown); end
        Clear = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            checks++;
            if (bus.GearIsDown !== ((e < 6) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL middeb edge %0d got %b want %b", e, bus.GearIsDown,
                         (e < 6) ? 1'b1 : 1'b0);
            end
        end
    endtask

    task automatic test_simultaneous();
        // DownRaw is 0 here, so raising UpRaw must not flag a fault.
        bus.LeverRaw  = 1'b0;
        bus.GroundRaw = 1'b0;
        bus.UpRaw     = 1'b1;
        tick(5);
        checks++;
        if ({bus.Lever, bus.PlaneOnGround, bus.GearIsUp} !== 3'b110) begin
            fails++;
            $display("FAIL simul_early got %b%b%b want 110", bus.Lever, bus.PlaneOnGround,
                     bus.GearIsUp);
        end
        tick(1);
        checks++;
        if ({bus.Lever, bus.PlaneOnGround, bus.GearIsUp} !== 3'b001) begin
            fails++;
            $display("FAIL simul_change got %b%b%b want 001", bus.Lever, bus.PlaneOnGround,
                     bus.GearIsUp);
        end
        tick(2);
        checks++; if (bus.SensorFault !== 1'b0) begin fails++;
            $display("FAIL simul_fault got %b want 0", bus.SensorFault); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_lever_debounce();
        test_glitch();
        test_timer();
        test_fault();
        test_reset_mid_debounce();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
